ps2_keyboard_rx: RTL

- PS/2 keyboard receive front end; sits directly upstream of the key decoder inside ctrl_main_block.
- Synchronises and filters the raw ps2_clk/ps2_data pins and deframes 11-bit device-to-host frames: start, 8 data bits LSB first, odd parity, stop.
- Strips the F0 (break) and E0 (extended) prefixes and emits one qualified key event per make/break code.
- Drives a single-cycle valid strobe and a frame-error strobe into the game controller's key handling.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_sync_filter.sv | 44 ++++
 rtl/ps2_keyboard_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and frame check helper for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  // Odd parity over data+parity and a high stop bit make a good frame.
  function automatic logic frame_ok(input logic [7:0] data, input logic parity,
                                    input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser, run-length glitch filter and falling-edge strobe
// for the PS/2 clock line. Everything idles high, like the bus.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_reg;
  logic          filt_reg;
  logic          fall_reg;
  logic [CW-1:0] run_reg;

  // Synchronise, then move the filtered level only after FILTER_LEN
  // consecutive samples disagree with it; flag a 1->0 move for one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg <= 2'b11;
      filt_reg <= 1'b1;
      fall_reg <= 1'b0;
      run_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pin};
      fall_reg <= 1'b0;
      if (sync_reg[1] == filt_reg) begin
        run_reg <= '0;
      end else if (run_reg == CW'(FILTER_LEN - 1)) begin
        filt_reg <= sync_reg[1];
        fall_reg <= ~sync_reg[1];
        run_reg  <= '0;
      end else begin
        run_reg <= run_reg + CW'(1);
      end
    end
  end

  assign fall = fall_reg;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit device-to-host frames, folds the
// F0/E0 prefixes into flags and emits one strobed key event per scan code.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       key_release,
  output logic       ext_key,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  logic          strobe;
  logic [1:0]    dsync_reg;
  logic          data_s;

  ps2_rx_state_t state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    sh_reg, sh_next;
  logic          par_reg, par_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          rel_pend_reg, rel_pend_next;
  logic          ext_pend_reg, ext_pend_next;
  logic [7:0]    code_reg, code_next;
  logic          rel_reg, rel_next;
  logic          ext_reg, ext_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_clk),
    .fall  (strobe)
  );

  // Data only needs synchronising: it is sampled mid-low-phase where it is stable.
  always_ff @(posedge clk) begin
    if (!reset) dsync_reg <= 2'b11;
    else        dsync_reg <= {dsync_reg[0], ps2_data};
  end
  assign data_s = dsync_reg[1];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      sh_reg       <= '0;
      par_reg      <= 1'b0;
      tmo_reg      <= '0;
      rel_pend_reg <= 1'b0;
      ext_pend_reg <= 1'b0;
      code_reg     <= '0;
      rel_reg      <= 1'b0;
      ext_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      sh_reg       <= sh_next;
      par_reg      <= par_next;
      tmo_reg      <= tmo_next;
      rel_pend_reg <= rel_pend_next;
      ext_pend_reg <= ext_pend_next;
      code_reg     <= code_next;
      rel_reg      <= rel_next;
      ext_reg      <= ext_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
    end
  end

  // Frame sequencing, prefix handling and the inactivity timeout.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    sh_next       = sh_reg;
    par_next      = par_reg;
    tmo_next      = tmo_reg;
    rel_pend_next = rel_pend_reg;
    ext_pend_next = ext_pend_reg;
    code_next     = code_reg;
    rel_next      = rel_reg;
    ext_next      = ext_reg;
    valid_next    = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        // A high "start" bit is line noise, not a frame.
        if (strobe && !data_s) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (strobe) begin
          sh_next      = {data_s, sh_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_next   = data_s;
          state_next = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_next = IDLE;
          if (frame_ok(sh_reg, par_reg, data_s)) begin
            if (sh_reg == PS2_BREAK) begin
              rel_pend_next = 1'b1;
            end else if (sh_reg == PS2_EXT) begin
              ext_pend_next = 1'b1;
            end else begin
              valid_next    = 1'b1;
              code_next     = sh_reg;
              rel_next      = rel_pend_reg;
              ext_next      = ext_pend_reg;
              rel_pend_next = 1'b0;
              ext_pend_next = 1'b0;
            end
          end else begin
            err_next      = 1'b1;
            rel_pend_next = 1'b0;
            ext_pend_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A strobe always wins over an expiring timeout. Pending prefixes survive
    // a timeout so a retransmitted code still carries them.
    if (state_reg == IDLE || strobe) begin
      tmo_next = '0;
    end else if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
      tmo_next   = '0;
      state_next = IDLE;
      err_next   = 1'b1;
    end else begin
      tmo_next = tmo_reg + TW'(1);
    end
  end

  assign scan_code   = code_reg;
  assign scan_valid  = valid_reg;
  assign key_release = rel_reg;
  assign ext_key     = ext_reg;
  assign frame_err   = err_reg;
  assign busy        = (state_reg != IDLE);

endmodule
